// File: rtl/gf16_horner.sv
// Purpose : Horner-rule polynomial evaluator over GF(2^16), sequencing an external two-cycle multiplier.
// Latency : n+1 coefficients with coef_valid held high -> res_valid 3n+1 edges after the edge that samples start.
// Backpres: coef_ready only in FIRST/COEF; res_valid/res/res_terms/res_ovf held stable until res_ready.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, x, m, busy           evaluation request, evaluation point, reduction poly, activity flag
//   coef_valid/coef/coef_last   coefficient stream (highest degree first), coef_ready handshake
//   res_valid/res/res_terms/    result, consumed-term count (saturating), saturation flag,
//   res_ovf/res_ready           held until res_ready
//   mul_req/mul_a/mul_b/mul_m   request and operands to the attached gmul16
//   mul_p/mul_rdy               product from gmul16, valid when mul_rdy is high
module gf16_horner #(
  parameter int DWIDTH = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] x,
  input  logic [DWIDTH-1:0] m,
  output logic              busy,
  input  logic              coef_valid,
  input  logic [DWIDTH-1:0] coef,
  input  logic              coef_last,
  output logic              coef_ready,
  output logic              res_valid,
  output logic [DWIDTH-1:0] res,
  output logic [CNT_W-1:0]  res_terms,
  output logic              res_ovf,
  input  logic              res_ready,
  output logic              mul_req,
  output logic [DWIDTH-1:0] mul_a,
  output logic [DWIDTH-1:0] mul_b,
  output logic [DWIDTH-1:0] mul_m,
  input  logic [DWIDTH-1:0] mul_p,
  input  logic              mul_rdy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_MUL   = 3'd2,
    S_COEF  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] x_r;
  logic [DWIDTH-1:0] m_r;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  // 0 on the first cycle of a multiply, 1 from the second cycle on.
  logic              mul_ph;

  logic              coef_fire;
  logic [DWIDTH-1:0] acc_fold;
  logic              cnt_full;
  logic [CNT_W-1:0]  cnt_next;
  logic              ovf_next;

  assign coef_fire = coef_valid & coef_ready;
  // Field addition is plain XOR: no carries, no growth.
  assign acc_fold  = acc ^ coef;
  // Term counter sticks at all-ones; any further accepted term marks overflow.
  assign cnt_full  = &cnt;
  assign cnt_next  = cnt_full ? cnt : cnt + CNT_W'(1);
  assign ovf_next  = ovf | cnt_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      x_r        <= '0;
      m_r        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      mul_ph     <= 1'b0;
      busy       <= 1'b0;
      coef_ready <= 1'b0;
      res_valid  <= 1'b0;
      res        <= '0;
      res_terms  <= '0;
      res_ovf    <= 1'b0;
      mul_req    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_m      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_r        <= x;
            m_r        <= m;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b1;
            coef_ready <= 1'b1;
            state      <= S_FIRST;
          end
        end

        S_FIRST: begin
          // Leading coefficient seeds the accumulator directly (0*x ^ c).
          if (coef_fire) begin
            acc        <= coef;
            cnt        <= CNT_W'(1);
            coef_ready <= 1'b0;
            if (coef_last) begin
              res_valid <= 1'b1;
              res       <= coef;
              res_terms <= CNT_W'(1);
              res_ovf   <= 1'b0;
              state     <= S_DONE;
            end else begin
              mul_req <= 1'b1;
              mul_a   <= coef;
              mul_b   <= x_r;
              mul_m   <= m_r;
              mul_ph  <= 1'b0;
              state   <= S_MUL;
            end
          end
        end

        S_MUL: begin
          // A product cannot be ready in the first request cycle, so a
          // mul_rdy there is bogus and is dropped.
          if (!mul_ph) begin
            mul_ph <= 1'b1;
          end else if (mul_rdy) begin
            acc        <= mul_p;
            mul_req    <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_m      <= '0;
            coef_ready <= 1'b1;
            state      <= S_COEF;
          end
        end

        S_COEF: begin
          // Leaving COEF always drops mul_req for this cycle, which gives the
          // multiplier its mandatory idle gap between operations.
          if (coef_fire) begin
            acc        <= acc_fold;
            cnt        <= cnt_next;
            ovf        <= ovf_next;
            coef_ready <= 1'b0;
            if (coef_last) begin
              res_valid <= 1'b1;
              res       <= acc_fold;
              res_terms <= cnt_next;
              res_ovf   <= ovf_next;
              state     <= S_DONE;
            end else begin
              mul_req <= 1'b1;
              mul_a   <= acc_fold;
              mul_b   <= x_r;
              mul_m   <= m_r;
              mul_ph  <= 1'b0;
              state   <= S_MUL;
            end
          end
        end

        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res       <= '0;
            res_terms <= '0;
            res_ovf   <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf16_horner.sv
// Purpose : Self-checking bench for gf16_horner with a behavioural two-cycle multiplier and a Horner reference model.
// Latency : checks res_valid timing against 3n+2 cycles counted from the start-sampling edge as cycle 1.
// Backpres: exercises gapped coef_valid and stalled res_ready; a second instance with CNT_W=2 runs in lockstep.
module tb_gf16_horner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x, m, coef;
  logic        coef_valid, coef_last, res_ready;

  logic        busy, coef_ready, res_valid, res_ovf, mul_req, mul_rdy;
  logic [15:0] res, mul_a, mul_b, mul_m, mul_p;
  logic [7:0]  res_terms;

  logic        busy2, coef_ready2, res_valid2, res_ovf2, mul_req2, mul_rdy2;
  logic [15:0] res2, mul_a2, mul_b2, mul_m2, mul_p2;
  logic [1:0]  res_terms2;

  int total = 0;
  int bad   = 0;

  logic [15:0] cq [0:511];
  logic [15:0] exp_x, exp_m;
  int          mul_cycles = 0;
  logic        inject_early = 1'b0;
  logic        ph, ph2;

  // Results of the most recent run_eval.
  logic [15:0] ev_res, ev_res2;
  logic [7:0]  ev_terms;
  logic [1:0]  ev_terms2;
  logic        ev_ovf, ev_ovf2, ev_busy_after, ev_rv_after;
  int          ev_lat, ev_unstable;

  always #5 clk = ~clk;

  gf16_horner #(.DWIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .m(m), .busy(busy),
    .coef_valid(coef_valid), .coef(coef), .coef_last(coef_last), .coef_ready(coef_ready),
    .res_valid(res_valid), .res(res), .res_terms(res_terms), .res_ovf(res_ovf), .res_ready(res_ready),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m), .mul_p(mul_p), .mul_rdy(mul_rdy)
  );

  gf16_horner #(.DWIDTH(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .m(m), .busy(busy2),
    .coef_valid(coef_valid), .coef(coef), .coef_last(coef_last), .coef_ready(coef_ready2),
    .res_valid(res_valid2), .res(res2), .res_terms(res_terms2), .res_ovf(res_ovf2), .res_ready(res_ready),
    .mul_req(mul_req2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_m(mul_m2), .mul_p(mul_p2), .mul_rdy(mul_rdy2)
  );

  // Field multiply: carry-less product, then reduce by x^16 + m.
  function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] mm);
    logic [31:0] p;
    logic [31:0] poly;
    p    = '0;
    poly = {15'd0, 1'b1, mm};
    for (int i = 0; i < 16; i++)
      if (b[i]) p ^= (32'(a) << i);
    for (int i = 31; i >= 16; i--)
      if (p[i]) p ^= (poly << (i - 16));
    return p[15:0];
  endfunction

  function automatic logic [15:0] horner(input int n, input logic [15:0] xv, input logic [15:0] mv);
    logic [15:0] acc;
    acc = cq[0];
    for (int i = 1; i < n; i++) acc = gf_mul(acc, xv, mv) ^ cq[i];
    return acc;
  endfunction

  // Behavioural gmul16: product valid on the second request cycle.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ph <= 1'b0; else ph <= mul_req ? ~ph : 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ph2 <= 1'b0; else ph2 <= mul_req2 ? ~ph2 : 1'b0;

  assign mul_rdy  = mul_req & (ph | inject_early);
  assign mul_p    = (mul_req & ph) ? gf_mul(mul_a, mul_b, mul_m) : 16'hDEAD;
  assign mul_rdy2 = mul_req2 & ph2;
  assign mul_p2   = (mul_req2 & ph2) ? gf_mul(mul_a2, mul_b2, mul_m2) : 16'hBEEF;

  // Multiplier-contract monitor: operands stable, x/m are the latched ones, bursts exactly 2 cycles.
  int          run = 0;
  logic [15:0] op_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else if (mul_req) begin
      if (run == 0) op_a = mul_a;
      else begin
        total++;
        if (mul_a !== op_a) begin bad++; $display("FAIL mul_a_stable got=%h want=%h", mul_a, op_a); end
      end
      total++;
      if ({mul_b, mul_m} !== {exp_x, exp_m}) begin
        bad++; $display("FAIL mul_bm got=%h/%h want=%h/%h", mul_b, mul_m, exp_x, exp_m);
      end
      run++;
      mul_cycles++;
    end else begin
      if (run != 0) begin
        total++;
        if (run != 2) begin bad++; $display("FAIL mul_req_len got=%0d want=2", run); end
      end
      run = 0;
    end
  end

  task automatic run_eval(input logic [15:0] xv, input logic [15:0] mv, input int n,
                          input int toggle, input int stall, input int busy_start);
    int idx, cyc;
    logic hs;
    exp_x = xv; exp_m = mv;
    @(negedge clk);
    start = 1'b1; x = xv; m = mv; res_ready = 1'b0;
    coef_valid = 1'b1; coef = cq[0]; coef_last = (n == 1);
    idx = 0; cyc = 0; ev_lat = -1;
    hs = coef_valid & coef_ready;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (busy_start != 0) begin start = 1'b1; x = ~xv; m = ~mv; end
      else start = 1'b0;
      if (hs) idx++;
      if (res_valid) begin ev_lat = cyc; break; end
      coef_valid = (idx < n) && (toggle == 0 || cyc % 2 == 0);
      coef       = coef_valid ? cq[idx] : 16'($urandom);
      coef_last  = coef_valid ? (idx == n - 1) : 1'($urandom);
      hs = coef_valid & coef_ready;
    end
    if (ev_lat < 0) begin
      total++; bad++; $display("FAIL eval_timeout n=%0d got=no res_valid want=res_valid", n);
    end
    start = 1'b0; coef_valid = 1'b0; x = 16'($urandom); m = 16'($urandom);
    ev_res = res; ev_terms = res_terms; ev_ovf = res_ovf;
    ev_res2 = res2; ev_terms2 = res_terms2; ev_ovf2 = res_ovf2;
    ev_unstable = 0;
    repeat (stall) begin
      @(posedge clk); @(negedge clk);
      if ({res_valid, res, res_terms, res_ovf} !== {1'b1, ev_res, ev_terms, ev_ovf}) ev_unstable++;
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    ev_busy_after = busy; ev_rv_after = res_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; x = '0; m = '0; coef = '0;
    coef_valid = 1'b0; coef_last = 1'b0; res_ready = 1'b0;
    #12;
    total++;
    if ({busy, coef_ready, res_valid, res, res_terms, res_ovf, mul_req, mul_a, mul_b, mul_m} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {busy, coef_ready, res_valid, res, res_terms, res_ovf, mul_req, mul_a, mul_b, mul_m});
    end
    total++;
    if ({busy2, coef_ready2, res_valid2, res2, res_terms2, res_ovf2, mul_req2} !== '0) begin
      bad++; $display("FAIL reset_outputs2 got=%h want=0", {busy2, res_valid2, res2, res_terms2});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_plan_vectors;
    int mc;
    cq[0] = 16'h0001; cq[1] = 16'h0000; cq[2] = 16'h0000;
    run_eval(16'h0002, 16'h100B, 3, 0, 0, 0);
    total++; if (ev_res !== 16'h0004) begin bad++; $display("FAIL tp1_res got=%h want=0004", ev_res); end
    total++; if (ev_terms !== 8'd3) begin bad++; $display("FAIL tp1_terms got=%0d want=3", ev_terms); end
    total++; if (ev_lat != 8) begin bad++; $display("FAIL tp1_latency got=%0d want=8", ev_lat); end
    total++; if (ev_busy_after !== 1'b0) begin bad++; $display("FAIL tp1_busy_drop got=%b want=0", ev_busy_after); end

    cq[0] = 16'h8000; cq[1] = 16'h0000;
    run_eval(16'h0002, 16'h100B, 2, 0, 0, 0);
    total++; if (ev_res !== 16'h100B) begin bad++; $display("FAIL tp2_res got=%h want=100b", ev_res); end
    total++; if (ev_terms !== 8'd2) begin bad++; $display("FAIL tp2_terms got=%0d want=2", ev_terms); end

    cq[0] = 16'h1234;
    mc = mul_cycles;
    run_eval(16'h0007, 16'h100B, 1, 0, 0, 0);
    total++; if (ev_res !== 16'h1234) begin bad++; $display("FAIL tp3_res got=%h want=1234", ev_res); end
    total++; if (ev_terms !== 8'd1) begin bad++; $display("FAIL tp3_terms got=%0d want=1", ev_terms); end
    total++; if (ev_lat != 2) begin bad++; $display("FAIL tp3_latency got=%0d want=2", ev_lat); end
    total++; if (mul_cycles != mc) begin bad++; $display("FAIL tp3_no_mul got=%0d want=0", mul_cycles - mc); end
  endtask

  task automatic test_x_zero_stall;
    cq[0] = 16'hAAAA; cq[1] = 16'h5555; cq[2] = 16'h0F0F;
    run_eval(16'h0000, 16'h100B, 3, 1, 5, 0);
    total++; if (ev_res !== 16'h0F0F) begin bad++; $display("FAIL xzero_res got=%h want=0f0f", ev_res); end
    total++; if (ev_unstable != 0) begin bad++; $display("FAIL stall_stable got=%0d changes want=0", ev_unstable); end
    total++; if ({ev_busy_after, ev_rv_after} !== 2'b00) begin
      bad++; $display("FAIL stall_release got=%b want=00", {ev_busy_after, ev_rv_after});
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 5; i++) cq[i] = 16'h0001;
    run_eval(16'h0001, 16'h100B, 5, 0, 0, 0);
    total++; if ({ev_res, ev_terms, ev_ovf} !== {16'h0001, 8'd5, 1'b0}) begin
      bad++; $display("FAIL sat5_wide got=%h/%0d/%b want=0001/5/0", ev_res, ev_terms, ev_ovf);
    end
    total++; if ({ev_res2, ev_terms2, ev_ovf2} !== {16'h0001, 2'd3, 1'b1}) begin
      bad++; $display("FAIL sat5_narrow got=%h/%0d/%b want=0001/3/1", ev_res2, ev_terms2, ev_ovf2);
    end
    for (int i = 0; i < 300; i++) cq[i] = 16'($urandom);
    run_eval(16'h1F2B, 16'h002D, 300, 0, 0, 0);
    total++; if (ev_res !== horner(300, 16'h1F2B, 16'h002D)) begin
      bad++; $display("FAIL sat300_res got=%h want=%h", ev_res, horner(300, 16'h1F2B, 16'h002D));
    end
    total++; if ({ev_terms, ev_ovf} !== {8'd255, 1'b1}) begin
      bad++; $display("FAIL sat300_terms got=%0d/%b want=255/1", ev_terms, ev_ovf);
    end
  endtask

  task automatic test_protocol_error;
    logic [15:0] want;
    for (int i = 0; i < 4; i++) cq[i] = 16'($urandom);
    inject_early = 1'b1;
    run_eval(16'h3A5C, 16'h100B, 4, 0, 0, 0);
    inject_early = 1'b0;
    want = horner(4, 16'h3A5C, 16'h100B);
    total++; if (ev_res !== want) begin bad++; $display("FAIL early_rdy_res got=%h want=%h", ev_res, want); end
    total++; if (ev_lat != 11) begin bad++; $display("FAIL early_rdy_latency got=%0d want=11", ev_lat); end
  endtask

  task automatic test_abort_and_restart;
    logic found;
    logic [15:0] want;
    exp_x = 16'h0003; exp_m = 16'h100B;
    @(negedge clk);
    start = 1'b1; x = exp_x; m = exp_m; coef_valid = 1'b1; coef = 16'h0011; coef_last = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (mul_req && ph) begin found = 1'b1; break; end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL abort_reach got=%b want=1", found); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, coef_ready, res_valid, res, res_terms, res_ovf, mul_req, mul_a, mul_b, mul_m} !== '0) begin
      bad++; $display("FAIL abort_outputs got=%h want=0",
        {busy, coef_ready, res_valid, res, res_terms, res_ovf, mul_req, mul_a, mul_b, mul_m});
    end
    coef_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    // Fresh evaluation with start (and garbage x/m) held high throughout.
    for (int i = 0; i < 4; i++) cq[i] = 16'($urandom);
    run_eval(16'h0105, 16'h1021, 4, 0, 0, 1);
    want = horner(4, 16'h0105, 16'h1021);
    total++; if (ev_res !== want) begin bad++; $display("FAIL busy_start_res got=%h want=%h", ev_res, want); end
    total++; if (ev_terms !== 8'd4) begin bad++; $display("FAIL busy_start_terms got=%0d want=4", ev_terms); end
  endtask

  task automatic test_random;
    int n, tog, st;
    logic [15:0] xv, mv, want;
    for (int it = 0; it < 10; it++) begin
      n   = $urandom_range(1, 10);
      tog = $urandom_range(0, 1);
      st  = $urandom_range(0, 3);
      xv  = 16'($urandom);
      mv  = 16'($urandom);
      for (int i = 0; i < n; i++) cq[i] = 16'($urandom);
      run_eval(xv, mv, n, tog, st, 0);
      want = horner(n, xv, mv);
      total++; if (ev_res !== want) begin bad++; $display("FAIL rand_res it=%0d got=%h want=%h", it, ev_res, want); end
      total++; if (ev_terms !== 8'(n)) begin bad++; $display("FAIL rand_terms it=%0d got=%0d want=%0d", it, ev_terms, n); end
      total++; if ({ev_res2, ev_terms2, ev_ovf2} !== {want, 2'((n > 3) ? 3 : n), 1'(n > 3)}) begin
        bad++; $display("FAIL rand_narrow it=%0d got=%h/%0d/%b n=%0d", it, ev_res2, ev_terms2, ev_ovf2, n);
      end
      total++; if (ev_unstable != 0) begin bad++; $display("FAIL rand_stall it=%0d got=%0d want=0", it, ev_unstable); end
      if (tog == 0) begin
        total++; if (ev_lat != 3 * (n - 1) + 2) begin
          bad++; $display("FAIL rand_latency it=%0d got=%0d want=%0d", it, ev_lat, 3 * (n - 1) + 2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_x_zero_stall();
    test_saturation();
    test_protocol_error();
    test_abort_and_restart();
    test_random();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gf16_horner.md
Name: gf16_horner

Overview:
Sequencer that evaluates a polynomial over GF(2^16) by Horner's rule: acc = acc*x ^ c_i across a streamed coefficient sequence, highest-degree coefficient first. It sits directly upstream of the two-cycle GF(2^16) multiplier (gmul16). It drives that multiplier's req/a/b/m, consumes p on rdy, and folds in each new coefficient. Used by the ECC/CRC-style syndrome and hash paths of the pipeline.

Parameters:
DWIDTH, 16, field element width; must match the attached multiplier.
CNT_W, 8, width of the term counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin evaluation; sampled only in IDLE
x  input  DWIDTH  evaluation point; latched on start
m  input  DWIDTH  reduction polynomial, low DWIDTH bits; latched on start
busy  output  1  high whenever state != IDLE
coef_valid  input  1  coefficient available
coef  input  DWIDTH  coefficient value
coef_last  input  1  marks constant term (final coefficient)
coef_ready  output  1  coefficient accepted when coef_valid & coef_ready
res_valid  output  1  result valid; held until res_ready
res  output  DWIDTH  polynomial value
res_terms  output  CNT_W  number of coefficients consumed (saturating)
res_ovf  output  1  term counter saturated during this evaluation
res_ready  input  1  result consumer ready
mul_req  output  1  multiplier request
mul_a  output  DWIDTH  multiplicand (acc)
mul_b  output  DWIDTH  multiplier (latched x)
mul_m  output  DWIDTH  latched m
mul_p  input  DWIDTH  multiplier product
mul_rdy  input  1  product valid this cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, x_r=0, m_r=0, cnt=0, ovf=0. All outputs 0: busy, coef_ready, res_valid, res, res_terms, res_ovf, mul_req, mul_a/b/m.
- Multiplier contract: mul_req high for exactly two consecutive cycles with mul_a/b/m stable. mul_rdy=1 and mul_p valid in the second cycle. mul_req must drop for at least one cycle between operations so the multiplier phase returns to 0.
- States:
  - IDLE: coef_ready=0. On start: latch x,m; acc=0, cnt=0, ovf=0; go FIRST.
  - FIRST: coef_ready=1. On accept: acc=coef, cnt=1. If coef_last, go DONE; else go MUL.
  - MUL: mul_req=1, mul_a=acc, mul_b=x_r, mul_m=m_r, coef_ready=0. On mul_rdy: acc=mul_p, go COEF. mul_rdy on the first MUL cycle is a protocol error: ignore it and stay in MUL.
  - COEF: mul_req=0, coef_ready=1. On accept: acc=acc^coef, cnt=cnt+1 (saturate at 2^CNT_W-1 and set ovf). If coef_last, go DONE; else go MUL.
  - DONE: res_valid=1, res=acc, res_terms=cnt, res_ovf=ovf, stable while res_ready=0. On res_valid&res_ready, go IDLE; busy drops the next cycle.
- Latency: with coef_valid held high and n+1 coefficients, res_valid rises 3n+2 cycles after the start edge. Per extra term, throughput is 3 cycles (2 MUL + 1 COEF).
- start while busy is ignored. coef inputs in IDLE/MUL/DONE are ignored (coef_ready=0).
- x=0: every product is 0, so res is the last coefficient.
- Addition is bitwise XOR. No carries, no width growth.
- Reset mid-operation aborts immediately. The next evaluation requires a fresh start.

Test Plan:
- m=0x100B, x=0x0002, coefs 0x0001,0x0000,0x0000(last) -> res=0x0004, res_terms=3, res_valid at start+8 cycles.
- m=0x100B, x=0x0002, coefs 0x8000,0x0000(last) -> res=0x100B (reduction exercised), res_terms=2.
- Single coef 0x1234 with last -> res=0x1234, res_terms=1, mul_req never asserted; res_valid at start+2.
- x=0x0000, coefs 0xAAAA,0x5555,0x0F0F(last); coef_valid toggled every other cycle; res_ready held low 5 cycles -> res=0x0F0F, stable during stall, mul_req low ≥1 cycle between ops.
- CNT_W=2, 5 coefs all 0x0001 with x=0x0001 -> res=0x0001, res_terms=3, res_ovf=1.
- Drop rst_n during second MUL cycle -> all outputs 0 next sample. start ignored while busy on a fresh run; the next evaluation is correct.
